// File: rtl/spi_result_tx_if.sv
// SPI pin bundle between the host (master) and the result transmitter (slave).
interface spi_result_tx_if;
    logic spi_sck;
    logic spi_cs_n;
    logic spi_miso;
    logic spi_miso_oe;

    modport master (output spi_sck, output spi_cs_n, input spi_miso, input spi_miso_oe);
    modport slave  (input spi_sck, input spi_cs_n, output spi_miso, output spi_miso_oe);
endinterface

// File: rtl/spi_result_tx.sv
// Snapshots the RAM test error count and serves it to an SPI mode-0 host
// as a 32-bit frame: header, status, count high byte, count low byte.
module spi_result_tx #(
    parameter logic [7:0]  HEADER      = 8'hA5,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic           sys_clk,
    input  logic           all_clear_n,
    input  logic           ready_to_SPI,
    input  logic [15:0]    err_count,
    spi_result_tx_if.slave spi,
    output logic           result_valid,
    output logic           tx_done
);
    localparam int unsigned FRAME_W = 32;
    localparam int unsigned CNT_W   = 6;
    localparam int unsigned RES_W   = 16;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    typedef struct packed {
        logic [7:0]       header;
        logic [7:0]       status;
        logic [RES_W-1:0] count;
    } frame_t;

    state_t                 state_q, state_d;
    logic [FRAME_W-1:0]     shift_q, shift_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [RES_W-1:0]       result_q, result_d;
    logic                   result_valid_q, result_valid_d;
    logic                   pend_q, pend_d;
    logic                   miso_q, miso_d;
    logic                   oe_q, oe_d;
    logic                   tx_done_q, tx_done_d;

    logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q;
    logic                   sck_prev_q, cs_prev_q, rdy_prev_q;
    logic                   sck_rise, sck_fall, cs_rise, cs_fall, snap, sat;
    frame_t                 frame;

    // Synchronizers run through reset so a reset with cs_n held low cannot fake a cs_n edge.
    always_ff @(posedge sys_clk) begin
        sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], spi.spi_sck};
        cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], spi.spi_cs_n};
        sck_prev_q <= sck_sync_q[SYNC_STAGES-1];
        cs_prev_q  <= cs_sync_q[SYNC_STAGES-1];
        rdy_prev_q <= ready_to_SPI;
    end

    assign sck_rise = sck_sync_q[SYNC_STAGES-1] & ~sck_prev_q;
    assign sck_fall = ~sck_sync_q[SYNC_STAGES-1] & sck_prev_q;
    assign cs_rise  = cs_sync_q[SYNC_STAGES-1] & ~cs_prev_q;
    assign cs_fall  = ~cs_sync_q[SYNC_STAGES-1] & cs_prev_q;
    assign snap     = ready_to_SPI & ~rdy_prev_q;
    assign sat      = (result_q == 16'hFFFF);

    always_ff @(posedge sys_clk) begin
        if (!all_clear_n) begin
            state_q        <= IDLE;
            shift_q        <= '0;
            cnt_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            pend_q         <= 1'b0;
            miso_q         <= 1'b0;
            oe_q           <= 1'b0;
            tx_done_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            shift_q        <= shift_d;
            cnt_q          <= cnt_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            pend_q         <= pend_d;
            miso_q         <= miso_d;
            oe_q           <= oe_d;
            tx_done_q      <= tx_done_d;
        end
    end

    // pend marks a snapshot taken after the current frame was loaded; completion must not consume it.
    always_comb begin
        state_d        = state_q;
        shift_d        = shift_q;
        cnt_d          = cnt_q;
        result_d       = snap ? err_count : result_q;
        result_valid_d = result_valid_q;
        pend_d         = pend_q | snap;
        tx_done_d      = 1'b0;
        frame.header   = HEADER;
        frame.status   = {result_valid_q, sat, 6'b0};
        frame.count    = result_q;

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = SHIFT;
                    shift_d = frame;
                    cnt_d   = '0;
                    pend_d  = snap;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d = IDLE;
                end else begin
                    if (sck_fall) shift_d = {shift_q[FRAME_W-2:0], 1'b0};
                    if (sck_rise) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_d == CNT_W'(FRAME_W)) begin
                            state_d   = DONE;
                            tx_done_d = 1'b1;
                            if (!pend_q) result_valid_d = 1'b0;
                        end
                    end
                end
            end
            DONE: begin
                if (cs_rise) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (snap) result_valid_d = 1'b1;
        miso_d = (state_d == SHIFT) ? shift_d[FRAME_W-1] : 1'b0;
        oe_d   = (state_d != IDLE);
    end

    assign spi.spi_miso    = miso_q;
    assign spi.spi_miso_oe = oe_q;
    assign result_valid    = result_valid_q;
    assign tx_done         = tx_done_q;
endmodule

// File: tb/tb_spi_result_tx.sv
// Bench for spi_result_tx: a host model drives frames, a monitor captures MISO
// and compares each completed frame against a queue of expected frames.
module tb_spi_result_tx;
    logic        sys_clk = 1'b0;
    logic        all_clear_n;
    logic        ready_to_SPI;
    logic [15:0] err_count;
    logic        result_valid;
    logic        tx_done;

    spi_result_tx_if spi();

    spi_result_tx #(.HEADER(8'hA5), .SYNC_STAGES(2)) dut (
        .sys_clk      (sys_clk),
        .all_clear_n  (all_clear_n),
        .ready_to_SPI (ready_to_SPI),
        .err_count    (err_count),
        .spi          (spi),
        .result_valid (result_valid),
        .tx_done      (tx_done)
    );

    always #5 sys_clk = ~sys_clk;

    int          n_vec     = 0;
    int          n_err     = 0;
    int          done_cnt  = 0;
    int          exp_done  = 0;
    logic        prev_done = 1'b0;
    logic [31:0] rx_word   = '0;
    logic [31:0] exp_q[$];

    task automatic check1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Host-side capture of MISO at each mode-0 sampling edge.
    always @(negedge spi.spi_cs_n) rx_word = '0;
    always @(posedge spi.spi_sck) if (!spi.spi_cs_n) rx_word = {rx_word[30:0], spi.spi_miso};

    // Monitor: every tx_done pulse retires one expected frame.
    initial begin
        forever begin
            @(negedge sys_clk);
            if (tx_done === 1'b1) begin
                if (prev_done) begin
                    check1("tx_done_width", prev_done, 1'b0);
                end else begin
                    done_cnt++;
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_frame: got %h expected none", rx_word);
                    end else begin
                        check32("frame", rx_word, exp_q.pop_front());
                    end
                end
            end
            prev_done = tx_done;
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Host transfer of nbits; optional snapshot or one-cycle reset injected at a bit index.
    task automatic spi_read(input int nbits, input int snap_at, input logic [15:0] snap_val,
                            input int rst_at);
        @(negedge sys_clk);
        #2;
        spi.spi_cs_n = 1'b0;
        #100;
        check1("oe_selected", spi.spi_miso_oe, 1'b1);
        for (int i = 0; i < nbits; i++) begin
            if (i == snap_at) begin
                err_count    = snap_val;
                ready_to_SPI = 1'b1;
            end
            if (i == rst_at) begin
                @(negedge sys_clk);
                all_clear_n = 1'b0;
                @(negedge sys_clk);
                all_clear_n = 1'b1;
                @(negedge sys_clk);
                check1("oe_after_reset", spi.spi_miso_oe, 1'b0);
                check1("rv_after_reset", result_valid, 1'b0);
                check1("miso_after_reset", spi.spi_miso, 1'b0);
                #2;
            end
            spi.spi_sck = 1'b1;
            #50;
            spi.spi_sck = 1'b0;
            #50;
        end
        #100;
        spi.spi_cs_n = 1'b1;
        #200;
    endtask

    task automatic snapshot(input logic [15:0] val);
        ready_to_SPI = 1'b0;
        repeat (3) @(negedge sys_clk);
        err_count = val;
        @(negedge sys_clk);
        ready_to_SPI = 1'b1;
        repeat (3) @(negedge sys_clk);
    endtask

    initial begin
        all_clear_n  = 1'b0;
        ready_to_SPI = 1'b0;
        err_count    = '0;
        spi.spi_cs_n = 1'b1;
        spi.spi_sck  = 1'b0;
        repeat (5) @(negedge sys_clk);
        check1("reset_rv", result_valid, 1'b0);
        check1("reset_tx_done", tx_done, 1'b0);
        check1("reset_miso", spi.spi_miso, 1'b0);
        check1("reset_oe", spi.spi_miso_oe, 1'b0);
        all_clear_n = 1'b1;
        repeat (3) @(negedge sys_clk);

        // First snapshot and full read.
        snapshot(16'h0123);
        check1("rv_snap_0123", result_valid, 1'b1);
        exp_q.push_back(32'hA580_0123);
        exp_done++;
        spi_read(32, -1, 16'h0, -1);
        check1("rv_after_read1", result_valid, 1'b0);
        check32("done_count_1", 32'(done_cnt), 32'(exp_done));

        // Re-read without a new snapshot.
        exp_q.push_back(32'hA500_0123);
        exp_done++;
        spi_read(32, -1, 16'h0, -1);
        check1("rv_after_reread", result_valid, 1'b0);
        check32("done_count_2", 32'(done_cnt), 32'(exp_done));

        // Saturated count.
        snapshot(16'hFFFF);
        exp_q.push_back(32'hA5C0_FFFF);
        exp_done++;
        spi_read(32, -1, 16'h0, -1);
        check1("rv_after_sat", result_valid, 1'b0);

        // Aborted read keeps the snapshot pending.
        snapshot(16'h1234);
        spi_read(12, -1, 16'h0, -1);
        check1("rv_after_abort", result_valid, 1'b1);
        check32("done_count_abort", 32'(done_cnt), 32'(exp_done));
        exp_q.push_back(32'hA580_1234);
        exp_done++;
        spi_read(32, -1, 16'h0, -1);
        check1("rv_after_full", result_valid, 1'b0);

        // Snapshot arriving mid-frame does not alter the frame in flight.
        ready_to_SPI = 1'b0;
        repeat (3) @(negedge sys_clk);
        exp_q.push_back(32'hA500_1234);
        exp_done++;
        spi_read(32, 10, 16'h0007, -1);
        check1("rv_after_midsnap", result_valid, 1'b1);
        check32("done_count_mid", 32'(done_cnt), 32'(exp_done));
        exp_q.push_back(32'hA580_0007);
        exp_done++;
        spi_read(32, -1, 16'h0, -1);
        check1("rv_after_0007", result_valid, 1'b0);

        // Reset mid-frame with ready_to_SPI still high.
        spi_read(32, -1, 16'h0, 20);
        check1("rv_no_snap_after_reset", result_valid, 1'b0);
        check32("done_count_rst", 32'(done_cnt), 32'(exp_done));
        exp_q.push_back(32'hA500_0000);
        exp_done++;
        spi_read(32, -1, 16'h0, -1);
        check32("done_count_final", 32'(done_cnt), 32'(exp_done));
        check32("pending_frames", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
